// File: rtl/alu_pkg.sv
// ALU package: opcode type, opcode constants and datapath width default.
package alu_pkg;

    localparam int unsigned ALU_WIDTH  = 8;
    localparam int unsigned OP_WIDTH   = 3;

    typedef logic [OP_WIDTH-1:0] alu_op_t;

    localparam alu_op_t moveCode      = 3'd0;
    localparam alu_op_t incrementCode = 3'd1;
    localparam alu_op_t addCode       = 3'd2;
    localparam alu_op_t subCode       = 3'd3;
    localparam alu_op_t andCode       = 3'd4;
    localparam alu_op_t orCode        = 3'd5;
    localparam alu_op_t xorCode       = 3'd6;
    localparam alu_op_t notCode       = 3'd7;

endpackage

// File: rtl/alu_flags.sv
// ALU status flags: computes zero/carry/sign/overflow (and optional parity)
// from the operands and the combinational result, and registers them.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   flag_we       load enable for all flag registers
//   op            current opcode
//   a, b          operands (accumulator, data)
//   result        combinational ALU result
//   zero_q, carry_q, neg_q, ovf_q, parity_q   registered flags
//
// Optional feature: define ALU_PARITY_EN to register the even-parity flag;
// otherwise parity_q is tied to 0.
module alu_flags
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flag_we,
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] result,
    output logic             zero_q,
    output logic             carry_q,
    output logic             neg_q,
    output logic             ovf_q,
    output logic             parity_q
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH:0] add_wide;
    logic           carry_c;
    logic           ovf_c;

    assign add_wide = {1'b0, a} + {1'b0, b};

    // Carry/borrow and signed overflow for the arithmetic opcodes.
    always_comb begin
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        case (op)
            addCode: begin
                carry_c = add_wide[WIDTH];
                ovf_c   = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
            end
            incrementCode: begin
                // Second operand is +1, always non-negative.
                carry_c = &a;
                ovf_c   = !a[MSB] && result[MSB];
            end
            subCode: begin
                carry_c = (a < b);
                ovf_c   = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
            end
            default: begin
                carry_c = 1'b0;
                ovf_c   = 1'b0;
            end
        endcase
    end

    // Flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (flag_we) begin
            zero_q  <= (result == '0);
            carry_q <= carry_c;
            neg_q   <= result[MSB];
            ovf_q   <= ovf_c;
        end
    end

`ifdef ALU_PARITY_EN
    // Even parity: 1 when result has an even number of ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (flag_we) begin
            parity_q <= ~^result;
        end
    end
`else
    assign parity_q = 1'b0;
`endif

endmodule

// File: rtl/alu.sv
// ALU top: combinational result mux plus registered status flags.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset (flags only)
//   data               operand B
//   from_accumulator   operand A
//   aluOpe             opcode (alu_pkg)
//   flag_we            flag register write enable
//   out                combinational result (never registered)
//   zero_q, carry_q, neg_q, ovf_q, parity_q   registered flags
//
// Optional feature: define ALU_PARITY_EN to enable the parity flag.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] from_accumulator,
    input  alu_op_t          aluOpe,
    input  logic             flag_we,
    output logic [WIDTH-1:0] out,
    output logic             zero_q,
    output logic             carry_q,
    output logic             neg_q,
    output logic             ovf_q,
    output logic             parity_q
);

    // Result mux; arithmetic wraps modulo 2^WIDTH.
    always_comb begin
        out = '0;
        case (aluOpe)
            moveCode:      out = data;
            incrementCode: out = from_accumulator + WIDTH'(1);
            addCode:       out = from_accumulator + data;
            subCode:       out = from_accumulator - data;
            andCode:       out = from_accumulator & data;
            orCode:        out = from_accumulator | data;
            xorCode:       out = from_accumulator ^ data;
            notCode:       out = ~from_accumulator;
            default:       out = '0;
        endcase
    end

    alu_flags #(
        .WIDTH (WIDTH)
    ) u_flags (
        .clk      (clk),
        .rst_n    (rst_n),
        .flag_we  (flag_we),
        .op       (aluOpe),
        .a        (from_accumulator),
        .b        (data),
        .result   (out),
        .zero_q   (zero_q),
        .carry_q  (carry_q),
        .neg_q    (neg_q),
        .ovf_q    (ovf_q),
        .parity_q (parity_q)
    );

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: scoreboard queues of predicted results/flags.
module tb_alu;
    import alu_pkg::*;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         n;
        logic         v;
        logic         p;
    } exp_t;

    logic         clk;
    logic         clk_en;
    logic         rst_n;
    logic [W-1:0] data;
    logic [W-1:0] from_accumulator;
    alu_op_t      aluOpe;
    logic         flag_we;
    logic [W-1:0] out;
    logic         zero_q, carry_q, neg_q, ovf_q, parity_q;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] out_q[$];
    exp_t         flg_q[$];
    exp_t         held;

    alu #(.WIDTH(W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .data             (data),
        .from_accumulator (from_accumulator),
        .aluOpe           (aluOpe),
        .flag_we          (flag_we),
        .out              (out),
        .zero_q           (zero_q),
        .carry_q          (carry_q),
        .neg_q            (neg_q),
        .ovf_q            (ovf_q),
        .parity_q         (parity_q)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Reference model using signed integer arithmetic for overflow.
    function automatic exp_t model(input alu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   ua, ub, sa, sb, s;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        e = '0;
        case (op)
            moveCode:      e.res = b;
            incrementCode: begin
                e.res = W'(ua + 1);
                e.c   = (ua + 1) > 255;
                s     = sa + 1;
                e.v   = (s > 127) || (s < -128);
            end
            addCode: begin
                e.res = W'(ua + ub);
                e.c   = (ua + ub) > 255;
                s     = sa + sb;
                e.v   = (s > 127) || (s < -128);
            end
            subCode: begin
                e.res = W'(ua - ub);
                e.c   = ua < ub;
                s     = sa - sb;
                e.v   = (s > 127) || (s < -128);
            end
            andCode: e.res = a & b;
            orCode:  e.res = a | b;
            xorCode: e.res = a ^ b;
            default: e.res = ~a;
        endcase
        e.z = (e.res == 0);
        e.n = e.res[W-1];
`ifdef ALU_PARITY_EN
        e.p = ($countones(e.res) % 2) == 0;
`else
        e.p = 1'b0;
`endif
        return e;
    endfunction

    task automatic check_flags(input string tag, input exp_t e);
        check({tag, ".zero"},   32'(zero_q),   32'(e.z));
        check({tag, ".carry"},  32'(carry_q),  32'(e.c));
        check({tag, ".neg"},    32'(neg_q),    32'(e.n));
        check({tag, ".ovf"},    32'(ovf_q),    32'(e.v));
        check({tag, ".parity"}, 32'(parity_q), 32'(e.p));
    endtask

    // Drive one operation; optionally load flags on the following edge.
    task automatic apply(input alu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic load);
        exp_t  e;
        string tag;
        tag = $sformatf("op%0d_%02h_%02h", op, a, b);
        @(negedge clk);
        aluOpe = op;
        from_accumulator = a;
        data = b;
        flag_we = load;
        e = model(op, a, b);
        out_q.push_back(e.res);
        if (load) flg_q.push_back(e);
        #1;
        check({tag, ".out"}, 32'(out), 32'(out_q.pop_front()));
        if (load) begin
            @(posedge clk);
            #1;
            e = flg_q.pop_front();
            check_flags(tag, e);
            held = e;
            flag_we = 1'b0;
        end
    endtask

    initial begin
        clk = 1'b0;
        clk_en = 1'b1;
        rst_n = 1'b0;
        flag_we = 1'b1;
        data = 8'hFF;
        from_accumulator = 8'hFF;
        aluOpe = incrementCode;
        held = '0;

        // Flags stay 0 in reset even with flag_we high across edges.
        repeat (2) @(posedge clk);
        #1;
        check_flags("reset", exp_t'('0));
        @(negedge clk);
        flag_we = 1'b0;
        rst_n = 1'b1;

        // Directed vectors.
        apply(moveCode,      8'h55, 8'hAA, 1'b1);
        apply(incrementCode, 8'h0F, 8'h00, 1'b1);
        apply(incrementCode, 8'hFF, 8'h00, 1'b1);
        check("inc_ff.carry_const", 32'(carry_q), 32'd1);
        check("inc_ff.zero_const",  32'(zero_q),  32'd1);
        apply(incrementCode, 8'h7F, 8'h33, 1'b1);
        apply(addCode,       8'h03, 8'h05, 1'b1);
        apply(addCode,       8'h80, 8'h80, 1'b1);
        check("add_80.ovf_const",   32'(ovf_q),   32'd1);
        apply(subCode,       8'h08, 8'h02, 1'b1);
        apply(subCode,       8'h02, 8'h08, 1'b1);
        check("sub_02_08.out_const", 32'(out), 32'hFA);
        apply(subCode,       8'h80, 8'h01, 1'b1);

        // Logic ops with the clock stopped.
        @(negedge clk);
        clk_en = 1'b0;
        aluOpe = andCode; from_accumulator = 8'hAA; data = 8'hCC; #1;
        check("and_noclk", 32'(out), 32'h88);
        aluOpe = orCode; #1;
        check("or_noclk", 32'(out), 32'hEE);
        aluOpe = xorCode; #1;
        check("xor_noclk", 32'(out), 32'h66);
        aluOpe = notCode; from_accumulator = 8'h0F; #1;
        check("not_noclk", 32'(out), 32'hF0);
        clk_en = 1'b1;

        // Mid-cycle reset clears loaded flags immediately; out keeps following.
        apply(addCode, 8'h80, 8'h80, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_flags("midreset", exp_t'('0));
        aluOpe = moveCode; data = 8'h5A; #1;
        check("midreset.out", 32'(out), 32'h5A);
        rst_n = 1'b1;

        // Hold: flag_we low across an edge keeps flags.
        apply(subCode, 8'h02, 8'h08, 1'b1);
        apply(moveCode, 8'h00, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        check_flags("hold", held);

        // Parity cases.
        apply(moveCode, 8'h00, 8'h03, 1'b1);
        apply(moveCode, 8'h00, 8'h07, 1'b1);

        // Random vectors, all opcodes.
        for (int i = 0; i < 24; i++) begin
            apply(alu_op_t'($urandom_range(7, 0)), W'($urandom), W'($urandom), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
